mac_seq: RTL and testbench

Sequencer for one mac_module instance. It computes a bias-initialised dot product of LEN signed 8-bit operand pairs. Operands are fetched from two synchronous-read operand memories at BASE_A/BASE_B. The controller drives the MAC's enable, bias-load and operand inputs, captures the final accumulator and presents it on a valid/ready result port. It sits between the NPU job dispatcher (START/LEN/BASE/BIAS) and the MAC datapath plus its operand SRAMs.

---
 rtl/mac_seq.sv | 131 +++++++++++++
 tb/tb_mac_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mac_seq.sv
// Job sequencer for a single mac_module: fetches LEN signed operand pairs from two
// synchronous-read memories, runs a bias-initialised dot product and hands the result out.
module mac_seq #(
  parameter int LEN_W  = 8,
  parameter int ADDR_W = 8
) (
  input  logic              CLKEXT,
  input  logic              RST,
  input  logic              START,
  input  logic [LEN_W-1:0]  LEN,
  input  logic [ADDR_W-1:0] BASE_A,
  input  logic [ADDR_W-1:0] BASE_B,
  input  logic [15:0]       BIAS_IN,
  output logic              BUSY,
  output logic [ADDR_W-1:0] ADDR_A,
  output logic [ADDR_W-1:0] ADDR_B,
  output logic              MEM_RD,
  input  logic [7:0]        MEM_A_DATA,
  input  logic [7:0]        MEM_B_DATA,
  output logic              MAC_EN,
  output logic              MAC_RST,
  output logic [15:0]       MAC_BIAS,
  output logic [7:0]        MAC_A,
  output logic [7:0]        MAC_B,
  input  logic [15:0]       MAC_Y,
  output logic [15:0]       RESULT,
  output logic              RES_VALID,
  input  logic              RES_READY
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ACC  = 3'd2,
    ST_CAPT = 3'd3,
    ST_OUT  = 3'd4
  } state_t;

  state_t            state_r, state_s;
  logic [LEN_W-1:0]  len_r, idx_r;
  logic [ADDR_W-1:0] base_a_r, base_b_r;
  logic [15:0]       bias_r, result_r;
  logic              last_s;

  // State register, job parameter latches, element counter and result capture
  always_ff @(posedge CLKEXT) begin
    if (RST) begin
      state_r  <= ST_IDLE;
      len_r    <= '0;
      idx_r    <= '0;
      base_a_r <= '0;
      base_b_r <= '0;
      bias_r   <= '0;
      result_r <= '0;
    end else begin
      state_r <= state_s;
      case (state_r)
        ST_IDLE: begin
          if (START) begin
            len_r    <= LEN;
            base_a_r <= BASE_A;
            base_b_r <= BASE_B;
            bias_r   <= BIAS_IN;
            idx_r    <= '0;
          end
        end
        // idx never exceeds LEN, which fits LEN_W, so this cannot wrap
        ST_ACC:  idx_r    <= idx_r + LEN_W'(1);
        ST_CAPT: result_r <= MAC_Y;
        default: ;
      endcase
    end
  end

  // Next-state decode and Moore outputs for the MAC and operand memories
  always_comb begin
    state_s = state_r;
    MEM_RD  = 1'b0;
    ADDR_A  = '0;
    ADDR_B  = '0;
    MAC_EN  = 1'b0;
    MAC_RST = 1'b0;
    MAC_A   = 8'h00;
    MAC_B   = 8'h00;
    last_s  = (idx_r == (len_r - LEN_W'(1)));
    case (state_r)
      ST_IDLE: begin
        if (START) state_s = ST_LOAD;
        else       state_s = ST_IDLE;
      end
      ST_LOAD: begin
        MAC_EN  = 1'b1;
        MAC_RST = 1'b1;
        if (len_r != '0) begin
          MEM_RD  = 1'b1;
          ADDR_A  = base_a_r;
          ADDR_B  = base_b_r;
          state_s = ST_ACC;
        end else begin
          state_s = ST_CAPT;
        end
      end
      ST_ACC: begin
        MAC_EN = 1'b1;
        MAC_A  = MEM_A_DATA;
        MAC_B  = MEM_B_DATA;
        // Prefetch element idx+1 so its data lands in the next ACC cycle
        if (!last_s) begin
          MEM_RD  = 1'b1;
          ADDR_A  = base_a_r + ADDR_W'(idx_r) + ADDR_W'(1);
          ADDR_B  = base_b_r + ADDR_W'(idx_r) + ADDR_W'(1);
          state_s = ST_ACC;
        end else begin
          state_s = ST_CAPT;
        end
      end
      ST_CAPT: state_s = ST_OUT;
      ST_OUT: begin
        if (RES_READY) state_s = ST_IDLE;
        else           state_s = ST_OUT;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  assign BUSY      = (state_r != ST_IDLE);
  assign RES_VALID = (state_r == ST_OUT);
  assign RESULT    = result_r;
  assign MAC_BIAS  = bias_r;

endmodule

// File: tb/tb_mac_seq.sv
// Directed bench for mac_seq with a behavioural saturating MAC and two 1-cycle-latency
// operand memories; expected values are hand-computed constants.
module tb_mac_seq;

  logic        CLKEXT = 1'b0;
  logic        RST, START, RES_READY;
  logic [7:0]  LEN, BASE_A, BASE_B;
  logic [15:0] BIAS_IN;
  logic        BUSY, MEM_RD, MAC_EN, MAC_RST, RES_VALID;
  logic [7:0]  ADDR_A, ADDR_B, MEM_A_DATA, MEM_B_DATA, MAC_A, MAC_B;
  logic [15:0] MAC_BIAS, MAC_Y, RESULT;

  logic [7:0]  mem_a [256];
  logic [7:0]  mem_b [256];
  logic [7:0]  qa [$];
  logic [7:0]  qb [$];
  int          en_cnt = 0;
  int          n_total = 0;
  int          n_bad = 0;

  always #5 CLKEXT = ~CLKEXT;

  mac_seq dut (
    .CLKEXT(CLKEXT), .RST(RST), .START(START), .LEN(LEN), .BASE_A(BASE_A),
    .BASE_B(BASE_B), .BIAS_IN(BIAS_IN), .BUSY(BUSY), .ADDR_A(ADDR_A),
    .ADDR_B(ADDR_B), .MEM_RD(MEM_RD), .MEM_A_DATA(MEM_A_DATA),
    .MEM_B_DATA(MEM_B_DATA), .MAC_EN(MAC_EN), .MAC_RST(MAC_RST),
    .MAC_BIAS(MAC_BIAS), .MAC_A(MAC_A), .MAC_B(MAC_B), .MAC_Y(MAC_Y),
    .RESULT(RESULT), .RES_VALID(RES_VALID), .RES_READY(RES_READY)
  );

  function automatic logic [15:0] sat16(input int v);
    if (v > 32767)       return 16'h7FFF;
    else if (v < -32768) return 16'h8000;
    else                 return v[15:0];
  endfunction

  // Saturating MAC: bias load on RST_MAC, else accumulate A*B
  always @(posedge CLKEXT) begin
    if (MAC_EN) begin
      if (MAC_RST) MAC_Y <= MAC_BIAS;
      else MAC_Y <= sat16(int'($signed(MAC_Y)) + int'($signed(MAC_A)) * int'($signed(MAC_B)));
    end
  end

  // Operand memories and bus monitor
  always @(posedge CLKEXT) begin
    if (MEM_RD) begin
      MEM_A_DATA <= mem_a[ADDR_A];
      MEM_B_DATA <= mem_b[ADDR_B];
      qa.push_back(ADDR_A);
      qb.push_back(ADDR_B);
    end
    if (MAC_EN) en_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLKEXT);
    #1;
  endtask

  task automatic run_job(input string tag, input int len, input logic [7:0] ba,
                         input logic [7:0] bb, input logic [15:0] bias,
                         input logic [15:0] exp_res, input bit release_res);
    int n, rd0, en0;
    rd0 = qa.size();
    en0 = en_cnt;
    LEN = 8'(len); BASE_A = ba; BASE_B = bb; BIAS_IN = bias; START = 1'b1;
    n = 0;
    do begin
      tick();
      START = 1'b0;
      LEN = 8'hFF; BASE_A = 8'h00; BASE_B = 8'h00; BIAS_IN = 16'h1234;
      n++;
    end while (!RES_VALID && n < 600);
    chk({tag, "_lat"}, n, len + 3);
    chk({tag, "_res"}, RESULT, exp_res);
    chk({tag, "_nrd"}, qa.size() - rd0, len);
    chk({tag, "_nen"}, en_cnt - en0, len + 1);
    for (int i = 0; i < len; i++) begin
      if (rd0 + i < qa.size()) begin
        chk({tag, "_adra"}, qa[rd0 + i], 8'(ba + 8'(i)));
        chk({tag, "_adrb"}, qb[rd0 + i], 8'(bb + 8'(i)));
      end
    end
    if (release_res) begin
      RES_READY = 1'b1;
      tick();
      RES_READY = 1'b0;
      chk({tag, "_busy_after"}, BUSY, 1'b0);
      chk({tag, "_vld_after"}, RES_VALID, 1'b0);
      chk({tag, "_maca_idle"}, MAC_A, 8'h00);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_busy"}, BUSY, 1'b0);
    chk({tag, "_vld"}, RES_VALID, 1'b0);
    chk({tag, "_rd"}, MEM_RD, 1'b0);
    chk({tag, "_en"}, MAC_EN, 1'b0);
    chk({tag, "_mrst"}, MAC_RST, 1'b0);
    chk({tag, "_adra"}, ADDR_A, 8'h00);
    chk({tag, "_adrb"}, ADDR_B, 8'h00);
    chk({tag, "_bias"}, MAC_BIAS, 16'h0000);
    chk({tag, "_res"}, RESULT, 16'h0000);
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; RES_READY = 1'b0;
    LEN = 8'h00; BASE_A = 8'h00; BASE_B = 8'h00; BIAS_IN = 16'h0000;
    MAC_Y = 16'h0000; MEM_A_DATA = 8'h00; MEM_B_DATA = 8'h00;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 8'h00;
      mem_b[i] = 8'h00;
    end
    tick(); tick();
    chk_reset_outs("rst");
    RST = 1'b0;
    tick();

    // Basic dot product: 100 + 10 - 18 - 28 = 64
    mem_a[8'h10] = 8'd2;  mem_a[8'h11] = 8'hFD; mem_a[8'h12] = 8'd4;
    mem_b[8'h20] = 8'd5;  mem_b[8'h21] = 8'd6;  mem_b[8'h22] = 8'hF9;
    run_job("len3", 3, 8'h10, 8'h20, 16'd100, 16'h0040, 1'b1);

    // Empty vector returns the bias
    run_job("len0", 0, 8'h10, 8'h20, 16'hFFFB, 16'hFFFB, 1'b1);

    // Positive and negative saturation
    for (int i = 0; i < 4; i++) begin
      mem_a[8'h60 + 8'(i)] = 8'd127;
      mem_b[8'h70 + 8'(i)] = 8'd127;
      mem_a[8'h80 + 8'(i)] = 8'h80;
    end
    run_job("satp", 4, 8'h60, 8'h70, 16'h0000, 16'h7FFF, 1'b1);
    run_job("satn", 4, 8'h80, 8'h70, 16'h0000, 16'h8000, 1'b1);

    // Address wrap on A: 10 + 40 + 90 + 160 = 300
    mem_a[8'hFE] = 8'd1; mem_a[8'hFF] = 8'd2; mem_a[8'h00] = 8'd3; mem_a[8'h01] = 8'd4;
    mem_b[8'h40] = 8'd10; mem_b[8'h41] = 8'd20; mem_b[8'h42] = 8'd30; mem_b[8'h43] = 8'd40;
    run_job("wrap", 4, 8'hFE, 8'h40, 16'h0000, 16'h012C, 1'b1);

    // Back-pressure: result held, START ignored while the consumer stalls
    mem_a[8'h30] = 8'd3; mem_b[8'h50] = 8'd3;
    run_job("hold", 1, 8'h30, 8'h50, 16'd1, 16'd10, 1'b0);
    for (int i = 0; i < 5; i++) begin
      START = ~START;
      tick();
      chk("hold_vld", RES_VALID, 1'b1);
      chk("hold_res", RESULT, 16'd10);
      chk("hold_busy", BUSY, 1'b1);
    end
    START = 1'b0;
    RES_READY = 1'b1;
    tick();
    RES_READY = 1'b0;
    chk("hold_rel_busy", BUSY, 1'b0);
    chk("hold_rel_vld", RES_VALID, 1'b0);
    run_job("again", 3, 8'h10, 8'h20, 16'd100, 16'h0040, 1'b1);

    // Reset in the middle of accumulation
    LEN = 8'd10; BASE_A = 8'h90; BASE_B = 8'hA0; BIAS_IN = 16'd55; START = 1'b1;
    tick();
    START = 1'b0;
    tick(); tick(); tick();
    chk("mid_rd", MEM_RD, 1'b1);
    chk("mid_en", MAC_EN, 1'b1);
    RST = 1'b1;
    tick();
    chk_reset_outs("midrst");
    RST = 1'b0;
    mem_a[8'hB0] = 8'd1; mem_a[8'hB1] = 8'd1;
    mem_b[8'hC0] = 8'd3; mem_b[8'hC1] = 8'd4;
    run_job("post", 2, 8'hB0, 8'hC0, 16'h0000, 16'd7, 1'b1);

    // Reset beats a simultaneous START
    RST = 1'b1; START = 1'b1;
    tick();
    RST = 1'b0; START = 1'b0;
    chk("rst_start_busy", BUSY, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
